crop_window_stream: RTL and testbench

Streaming region-of-interest cropper: consumes a raster-order frame of IN_ROWS x IN_COLS pixels and forwards only the pixels inside a runtime-programmable window (origin X1/Y1, size W/H). It is the parametrised successor of the fixed-size crop stage and sits between the pixel source and downstream filters (e.g. the Gaussian stage). It adds per-frame config, window clipping, a registered output stage with full backpressure, and frame/line markers.

---
 rtl/crop_window_stream_if.sv | 34 +++
 rtl/crop_window_stream.sv | 194 +++++++++++++++++++
 tb/tb_crop_window_stream.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/crop_window_stream_if.sv
// rtl/crop_window_stream_if.sv - config, pixel-in and pixel-out stream bundle for crop_window_stream.
interface crop_window_stream_if #(
  parameter int PIXEL_BIT_WIDTH  = 12,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10
);
  localparam int CFG_W = 2 * (IMG_ROW_BITWIDTH + IMG_COL_BITWIDTH);

  logic [CFG_W-1:0]           crop_cfg_TDATA;
  logic                       crop_cfg_TVALID;
  logic                       crop_cfg_TREADY;
  logic [PIXEL_BIT_WIDTH-1:0] pixel_in_TDATA;
  logic                       pixel_in_TVALID;
  logic                       pixel_in_TREADY;
  logic [PIXEL_BIT_WIDTH-1:0] pixel_out_TDATA;
  logic                       pixel_out_TVALID;
  logic                       pixel_out_TREADY;
  logic                       pixel_out_TUSER;
  logic                       pixel_out_TLAST;

  modport master (
    output crop_cfg_TDATA, crop_cfg_TVALID, input crop_cfg_TREADY,
    output pixel_in_TDATA, pixel_in_TVALID, input pixel_in_TREADY,
    input  pixel_out_TDATA, pixel_out_TVALID, pixel_out_TUSER, pixel_out_TLAST,
    output pixel_out_TREADY
  );

  modport slave (
    input  crop_cfg_TDATA, crop_cfg_TVALID, output crop_cfg_TREADY,
    input  pixel_in_TDATA, pixel_in_TVALID, output pixel_in_TREADY,
    output pixel_out_TDATA, pixel_out_TVALID, pixel_out_TUSER, pixel_out_TLAST,
    input  pixel_out_TREADY
  );
endinterface

// File: rtl/crop_window_stream.sv
// rtl/crop_window_stream.sv - raster-order region-of-interest cropper with clipped runtime window.
// Optional CROP_SHADOW_CFG_EN: shadow config register for zero-gap back-to-back frames.
module crop_window_stream #(
  parameter int PIXEL_BIT_WIDTH  = 12,
  parameter int IN_ROWS          = 40,
  parameter int IN_COLS          = 40,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  crop_window_stream_if.slave  bus,
  output logic                 cfg_clipped
);
  localparam int R = IMG_ROW_BITWIDTH;
  localparam int C = IMG_COL_BITWIDTH;
  localparam logic [C:0]   COLS  = (C+1)'(IN_COLS);
  localparam logic [R:0]   ROWS  = (R+1)'(IN_ROWS);
  localparam logic [C-1:0] X_MAX = C'(IN_COLS - 1);
  localparam logic [R-1:0] Y_MAX = R'(IN_ROWS - 1);
  localparam logic [C:0]   ONE_C = (C+1)'(1);

  typedef enum logic {WAIT_CFG, STREAM} state_t;
  typedef struct packed {
    logic [C-1:0] x1;
    logic [R-1:0] y1;
    logic [C:0]   we;
    logic [R:0]   he;
  } win_t;

  state_t state_q, state_d;
  logic [C-1:0] x_q, x_d;
  logic [R-1:0] y_q, y_d;
  win_t win_q, win_d, cfg_win;
  logic clipped_q, clipped_d;
  logic out_valid_q, out_valid_d, out_user_q, out_user_d, out_last_q, out_last_d;
  logic [PIXEL_BIT_WIDTH-1:0] out_data_q, out_data_d;
`ifdef CROP_SHADOW_CFG_EN
  win_t shadow_q, shadow_d;
  logic shadow_valid_q, shadow_valid_d;
`endif

  logic [C-1:0] cfg_x1, cfg_w;
  logic [R-1:0] cfg_y1, cfg_h;
  logic [C:0]   x_room, x_ext, x_org, x_end;
  logic [R:0]   y_room, y_ext, y_org, y_end;
  logic cfg_clip, cfg_ready, in_ready, cfg_hs, in_hs, pass, first_px, last_px, frame_end;

  assign cfg_x1 = bus.crop_cfg_TDATA[C-1:0];
  assign cfg_y1 = bus.crop_cfg_TDATA[C+R-1:C];
  assign cfg_w  = bus.crop_cfg_TDATA[2*C+R-1:C+R];
  assign cfg_h  = bus.crop_cfg_TDATA[2*C+2*R-1:2*C+R];

  // Clip the requested window to the frame; all math one bit wider than coordinates.
  always_comb begin
    x_room     = COLS - {1'b0, cfg_x1};
    y_room     = ROWS - {1'b0, cfg_y1};
    cfg_win.x1 = cfg_x1;
    cfg_win.y1 = cfg_y1;
    cfg_win.we = '0;
    cfg_win.he = '0;
    if (({1'b0, cfg_x1} < COLS) && ({1'b0, cfg_y1} < ROWS)) begin
      cfg_win.we = ({1'b0, cfg_w} < x_room) ? {1'b0, cfg_w} : x_room;
      cfg_win.he = ({1'b0, cfg_h} < y_room) ? {1'b0, cfg_h} : y_room;
    end
    cfg_clip = (cfg_win.we != {1'b0, cfg_w}) || (cfg_win.he != {1'b0, cfg_h});
  end

  always_comb begin
    x_ext    = {1'b0, x_q};
    y_ext    = {1'b0, y_q};
    x_org    = {1'b0, win_q.x1};
    y_org    = {1'b0, win_q.y1};
    x_end    = x_org + win_q.we;
    y_end    = y_org + win_q.he;
    pass     = (x_ext >= x_org) && (x_ext < x_end) && (y_ext >= y_org) && (y_ext < y_end);
    first_px = (x_q == win_q.x1) && (y_q == win_q.y1);
    last_px  = (x_ext + ONE_C) == x_end;
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    win_d       = win_q;
    clipped_d   = clipped_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_user_d  = out_user_q;
    out_last_d  = out_last_q;
`ifdef CROP_SHADOW_CFG_EN
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
    cfg_ready      = (state_q == WAIT_CFG) || !shadow_valid_q;
`else
    cfg_ready      = (state_q == WAIT_CFG);
`endif
    in_ready  = (state_q == STREAM) && (!out_valid_q || bus.pixel_out_TREADY);
    cfg_hs    = cfg_ready && bus.crop_cfg_TVALID;
    in_hs     = in_ready && bus.pixel_in_TVALID;
    frame_end = in_hs && (x_q == X_MAX) && (y_q == Y_MAX);

    if (cfg_hs) begin
      clipped_d = cfg_clip;
      if (state_q == WAIT_CFG) begin
        win_d   = cfg_win;
        x_d     = '0;
        y_d     = '0;
        state_d = STREAM;
      end
`ifdef CROP_SHADOW_CFG_EN
      else begin
        shadow_d       = cfg_win;
        shadow_valid_d = 1'b1;
      end
`endif
    end

    if (in_hs) begin
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    if (frame_end) begin
`ifdef CROP_SHADOW_CFG_EN
      // A config arriving on the final handshake itself is taken directly.
      if (shadow_valid_q) begin
        win_d          = shadow_q;
        shadow_valid_d = 1'b0;
      end else if (cfg_hs) begin
        win_d          = cfg_win;
        shadow_valid_d = 1'b0;
      end else begin
        state_d = WAIT_CFG;
      end
`else
      state_d = WAIT_CFG;
`endif
    end

    if (in_hs && pass) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.pixel_in_TDATA;
      out_user_d  = first_px;
      out_last_d  = last_px;
    end else if (bus.pixel_out_TREADY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_CFG;
      x_q         <= '0;
      y_q         <= '0;
      win_q       <= '0;
      clipped_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_user_q  <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef CROP_SHADOW_CFG_EN
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      win_q       <= win_d;
      clipped_q   <= clipped_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_user_q  <= out_user_d;
      out_last_q  <= out_last_d;
`ifdef CROP_SHADOW_CFG_EN
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
`endif
    end
  end

  assign bus.crop_cfg_TREADY  = cfg_ready;
  assign bus.pixel_in_TREADY  = in_ready;
  assign bus.pixel_out_TVALID = out_valid_q;
  assign bus.pixel_out_TDATA  = out_data_q;
  assign bus.pixel_out_TUSER  = out_user_q;
  assign bus.pixel_out_TLAST  = out_last_q;
  assign cfg_clipped          = clipped_q;
endmodule

// File: tb/tb_crop_window_stream.sv
// tb/tb_crop_window_stream.sv - table-driven scoreboard bench for crop_window_stream on an 8x8 frame.
module tb_crop_window_stream;
  localparam int PW = 12;
  localparam int RB = 10;
  localparam int CB = 10;
  localparam int N  = 8;

  typedef struct {
    int x1; int y1; int w; int h;
    int mode;
    int exp_count; int exp_clip; int exp_first; int exp_last;
  } vec_t;

  typedef struct { int data; int user; int last; } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic cfg_clipped;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;
  int out_count = 0;
  int first_val = -1;
  int last_val = -1;
  exp_t sb[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  crop_window_stream_if #(.PIXEL_BIT_WIDTH(PW), .IMG_ROW_BITWIDTH(RB), .IMG_COL_BITWIDTH(CB)) bus();

  crop_window_stream #(
    .PIXEL_BIT_WIDTH(PW), .IN_ROWS(N), .IN_COLS(N),
    .IMG_ROW_BITWIDTH(RB), .IMG_COL_BITWIDTH(CB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .cfg_clipped(cfg_clipped)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Output monitor: scoreboard compare on handshake, hold check across stalls.
  initial begin
    int held_data, held_user, held_last;
    bit prev_stall;
    exp_t e;
    prev_stall = 0;
    held_data = 0; held_user = 0; held_last = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", int'(bus.pixel_out_TVALID), 1);
          check("stall_data", int'(bus.pixel_out_TDATA), held_data);
          check("stall_tuser", int'(bus.pixel_out_TUSER), held_user);
          check("stall_tlast", int'(bus.pixel_out_TLAST), held_last);
        end
        if (bus.pixel_out_TVALID && bus.pixel_out_TREADY) begin
          if (sb.size() == 0) begin
            check("unexpected_output", int'(bus.pixel_out_TDATA), -1);
          end else begin
            e = sb.pop_front();
            check("out_data", int'(bus.pixel_out_TDATA), e.data);
            check("out_tuser", int'(bus.pixel_out_TUSER), e.user);
            check("out_tlast", int'(bus.pixel_out_TLAST), e.last);
          end
          if (out_count == 0) first_val = int'(bus.pixel_out_TDATA);
          last_val = int'(bus.pixel_out_TDATA);
          out_count++;
        end
        prev_stall = bus.pixel_out_TVALID && !bus.pixel_out_TREADY;
        held_data  = int'(bus.pixel_out_TDATA);
        held_user  = int'(bus.pixel_out_TUSER);
        held_last  = int'(bus.pixel_out_TLAST);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.pixel_out_TREADY = 1'b1;
        1:       bus.pixel_out_TREADY = ~bus.pixel_out_TREADY;
        default: bus.pixel_out_TREADY = 1'b0;
      endcase
    end
  end

  task automatic send_cfg(input int x1, input int y1, input int w, input int h);
    bit ok = 0;
    bus.crop_cfg_TDATA  = {10'(h), 10'(w), 10'(y1), 10'(x1)};
    bus.crop_cfg_TVALID = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus.crop_cfg_TREADY) ok = 1;
    end
    check("cfg_accept", int'(ok), 1);
    @(posedge clk);
    #1;
    bus.crop_cfg_TVALID = 1'b0;
  endtask

  task automatic drive_frame(input int x1, input int y1, input int w, input int h, input int npix);
    int we, he, x, y;
    bit ok;
    exp_t e;
    if (x1 >= N || y1 >= N) begin
      we = 0; he = 0;
    end else begin
      we = (w < N - x1) ? w : N - x1;
      he = (h < N - y1) ? h : N - y1;
    end
    for (int p = 0; p < npix; p++) begin
      x = p % N;
      y = p / N;
      bus.pixel_in_TDATA  = PW'(y * N + x);
      bus.pixel_in_TVALID = 1'b1;
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
        @(negedge clk);
        if (bus.pixel_in_TREADY) ok = 1;
      end
      if (!ok) begin
        check("pixel_accept", 0, 1);
        bus.pixel_in_TVALID = 1'b0;
        return;
      end
      if (x >= x1 && x < x1 + we && y >= y1 && y < y1 + he) begin
        e.data = y * N + x;
        e.user = (x == x1 && y == y1) ? 1 : 0;
        e.last = (x == x1 + we - 1) ? 1 : 0;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    bus.pixel_in_TVALID = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() > 0; i++) @(posedge clk);
    check("drain_empty", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    ready_mode = v.mode;
    out_count = 0;
    first_val = -1;
    last_val = -1;
    send_cfg(v.x1, v.y1, v.w, v.h);
    drive_frame(v.x1, v.y1, v.w, v.h, N * N);
    drain();
    ready_mode = 0;
    check("out_count", out_count, v.exp_count);
    check("first_pixel", first_val, v.exp_first);
    check("last_pixel", last_val, v.exp_last);
    check("cfg_clipped", int'(cfg_clipped), v.exp_clip);
    check("wait_cfg_tready", int'(bus.crop_cfg_TREADY), 1);
    check("wait_cfg_in_ready", int'(bus.pixel_in_TREADY), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tail;
    vecs[0] = '{2, 3, 3, 2, 0, 6, 0, 26, 36};
    vecs[1] = '{2, 3, 3, 2, 1, 6, 0, 26, 36};
    vecs[2] = '{6, 7, 4, 3, 0, 2, 1, 62, 63};
    vecs[3] = '{2, 3, 0, 2, 0, 0, 0, -1, -1};
    vecs[4] = '{9, 0, 1, 1, 0, 0, 1, -1, -1};
    vecs[5] = '{0, 0, 8, 8, 1, 64, 0, 0, 63};
    vecs[6] = '{5, 0, 8, 8, 0, 24, 1, 5, 63};

    reset = 1'b1;
    bus.crop_cfg_TDATA   = '0;
    bus.crop_cfg_TVALID  = 1'b0;
    bus.pixel_in_TDATA   = '0;
    bus.pixel_in_TVALID  = 1'b0;
    bus.pixel_out_TREADY = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(bus.pixel_out_TVALID), 0);
    check("rst_out_data", int'(bus.pixel_out_TDATA), 0);
    check("rst_out_tuser", int'(bus.pixel_out_TUSER), 0);
    check("rst_out_tlast", int'(bus.pixel_out_TLAST), 0);
    check("rst_cfg_tready", int'(bus.crop_cfg_TREADY), 1);
    check("rst_in_tready", int'(bus.pixel_in_TREADY), 0);
    check("rst_clipped", int'(cfg_clipped), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset mid-frame with a pixel sitting in the output register.
    ready_mode = 0;
    send_cfg(0, 0, 8, 8);
    drive_frame(0, 0, 8, 8, 20);
    check("pre_reset_valid", int'(bus.pixel_out_TVALID), 1);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", int'(bus.pixel_out_TVALID), 0);
    check("midrst_in_tready", int'(bus.pixel_in_TREADY), 0);
    check("midrst_cfg_tready", int'(bus.crop_cfg_TREADY), 1);
    check("midrst_clipped", int'(cfg_clipped), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    tail = '{0, 0, 1, 1, 0, 1, 0, 0, 0};
    run_vec(tail);

`ifdef CROP_SHADOW_CFG_EN
    ready_mode = 0;
    out_count = 0;
    last_val = -1;
    send_cfg(2, 3, 3, 2);
    fork
      drive_frame(2, 3, 3, 2, N * N);
      begin
        repeat (10) @(posedge clk);
        #1;
        send_cfg(0, 0, 2, 1);
      end
    join
    check("shadow_no_gap", int'(bus.pixel_in_TREADY), 1);
    drive_frame(0, 0, 2, 1, N * N);
    drain();
    check("shadow_out_count", out_count, 8);
    check("shadow_last_pixel", last_val, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
